// File: rtl/multdiv.sv
// Multi-cycle multiply/divide unit for the EX stage: produces a {HI,LO} result
// and a one-cycle write strobe for the hilo register.
module multdiv #(
  parameter int unsigned MUL_CYCLES = 1,
  parameter logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [63:0] hilo_rddata,
  input  logic        flush,
  output logic        busy,
  output logic        hilo_we,
  output logic [63:0] hilo_wrdata
);

  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(31);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t        state;
  logic [2:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [63:0]   acc_q;
  logic [31:0]   quo;
  logic [31:0]   rem;
  logic [63:0]   result;
  logic [CW-1:0] cnt;

  logic          sgn;
  logic          is_div;
  logic [31:0]   dvd_mag;
  logic [63:0]   ext_a;
  logic [63:0]   ext_b;
  logic [63:0]   prod;
  logic [63:0]   mul_res;
  logic [31:0]   dvs;
  logic [32:0]   rem_sh;
  logic [32:0]   diff;
  logic          neg_q;
  logic          neg_r;
  logic [63:0]   fix_res;

  // Even op codes are the signed variants; ops 2/3 are the divides.
  assign sgn     = ~op_q[0];
  assign is_div  = (op[2:1] == 2'b01);
  assign dvd_mag = (!op[0] && reg1[31]) ? -reg1 : reg1;

  // Multiply datapath: sign/zero extend to 64 bits so the low 64 bits are exact.
  always_comb begin
    ext_a   = sgn ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b   = sgn ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod    = ext_a * ext_b;
    mul_res = prod;
    if (op_q[2]) mul_res = op_q[1] ? (acc_q - prod) : (acc_q + prod);
  end

  // Restoring divide step on magnitudes plus final sign fix-up.
  always_comb begin
    dvs     = (sgn && b_q[31]) ? -b_q : b_q;
    rem_sh  = {rem, quo[31]};
    diff    = rem_sh - {1'b0, dvs};
    neg_q   = sgn & (a_q[31] ^ b_q[31]);
    neg_r   = sgn & a_q[31];
    fix_res = {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};
    if (b_q == 32'd0) fix_res = {a_q, DIV_ZERO_Q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      quo    <= '0;
      rem    <= '0;
      result <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q  <= op;
            a_q   <= reg1;
            b_q   <= reg2;
            acc_q <= hilo_rddata;
            quo   <= dvd_mag;
            rem   <= '0;
            cnt   <= '0;
            state <= is_div ? DIV : MUL;
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == MUL_LAST) begin
            result <= mul_res;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            rem <= diff[32] ? rem_sh[31:0] : diff[31:0];
            quo <= {quo[30:0], ~diff[32]};
            if (cnt == DIV_LAST) state <= FIX;
            else                 cnt   <= cnt + CW'(1);
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            result <= fix_res;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign hilo_we     = (state == DONE) && !flush;
  assign hilo_wrdata = result;

endmodule

// File: tb/tb_multdiv.sv
// Directed bench for multdiv: latency, results, start-while-busy, flush and reset.
module tb_multdiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [63:0] hilo_rddata;
  logic        flush;
  logic        busy;
  logic        hilo_we;
  logic [63:0] hilo_wrdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multdiv #(.MUL_CYCLES(1), .DIV_ZERO_Q(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .reg1(reg1), .reg2(reg2),
    .hilo_rddata(hilo_rddata), .flush(flush), .busy(busy), .hilo_we(hilo_we),
    .hilo_wrdata(hilo_wrdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; afterwards we sit in cycle T+1.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] acc);
    op = o; reg1 = a; reg2 = b; hilo_rddata = acc; start = 1'b1;
    tick();
    start = 1'b0;
    reg1 = $urandom; reg2 = $urandom; hilo_rddata = {$urandom, $urandom};
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] acc, input logic [63:0] exp,
                        input int lat, input int pulse_at, input int idle_after);
    int extra_we;
    extra_we = 0;
    issue(o, a, b, acc);
    for (int k = 1; k <= lat + idle_after; k++) begin
      if (k > 1) tick();
      start = (k == pulse_at);
      if (k == pulse_at) op = 3'd1;
      if (k <= lat + 1) begin
        check($sformatf("%s busy c%0d", name, k), 64'(busy), 64'(k <= lat));
        check($sformatf("%s we c%0d", name, k), 64'(hilo_we), 64'(k == lat));
      end else if (hilo_we || busy) begin
        extra_we++;
      end
      if (k == lat) check($sformatf("%s data", name), hilo_wrdata, exp);
    end
    start = 1'b0;
    if (idle_after > 1) check($sformatf("%s idle activity", name), 64'(extra_we), 64'd0);
  endtask

  initial begin
    int cnt_we;
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0;
    reg1 = '0; reg2 = '0; hilo_rddata = '0;
    repeat (3) tick();
    check("reset busy", 64'(busy), 64'd0);
    check("reset we", 64'(hilo_we), 64'd0);
    check("reset data", hilo_wrdata, 64'd0);
    rst = 1'b1;
    tick();

    run_op("mult",  3'd0, 32'hFFFF_FFFD, 32'd5,         64'd0, 64'hFFFF_FFFF_FFFF_FFF1, 2, 0, 1);
    run_op("maddu", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFE_0000_0002, 2, 0, 1);
    run_op("msub",  3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 1);
    run_op("div -7/2",  3'd2, 32'hFFFF_FFF9, 32'd2,         64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0, 1);
    run_op("div 7/-2",  3'd2, 32'd7,         32'hFFFF_FFFE, 64'd0, 64'h0000_0001_FFFF_FFFD, 34, 0, 1);
    run_op("div ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000, 34, 0, 1);
    run_op("divu 100/7", 3'd3, 32'd100,      32'd7,         64'd0, 64'h0000_0002_0000_000E, 34, 0, 1);
    run_op("divu by0",  3'd3, 32'h8000_0000, 32'd0,         64'd0, 64'h8000_0000_FFFF_FFFF, 34, 5, 40);

    // Flush of a divide at T+10, then a multiply right behind it.
    issue(3'd3, 32'd100, 32'd7, 64'd0);
    for (int k = 2; k <= 10; k++) tick();
    flush = 1'b1;
    check("flush div busy", 64'(busy), 64'd1);
    check("flush div we", 64'(hilo_we), 64'd0);
    tick();
    flush = 1'b0;
    check("after flush busy", 64'(busy), 64'd0);
    check("after flush we", 64'(hilo_we), 64'd0);
    run_op("multu post-flush", 3'd1, 32'd2, 32'd3, 64'd0, 64'd6, 2, 0, 3);

    // Flush arriving in DONE kills the write strobe that same cycle.
    issue(3'd1, 32'd4, 32'd5, 64'd0);
    check("done flush busy c1", 64'(busy), 64'd1);
    tick();
    flush = 1'b1;
    #1;
    check("done flush we", 64'(hilo_we), 64'd0);
    tick();
    flush = 1'b0;
    check("done flush idle busy", 64'(busy), 64'd0);
    check("done flush idle we", 64'(hilo_we), 64'd0);

    // Flush together with start in IDLE drops the request.
    op = 3'd1; reg1 = 32'd3; reg2 = 32'd3; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("idle flush start busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a divide.
    tick();
    issue(3'd2, 32'd1000, 32'd3, 64'd0);
    for (int k = 2; k <= 20; k++) tick();
    check("pre-rst busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst we", 64'(hilo_we), 64'd0);
    tick();
    rst = 1'b1;
    cnt_we = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (hilo_we || busy) cnt_we++;
    end
    check("post-rst activity", 64'(cnt_we), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv.md
Name: multdiv

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the MIPS core.
- Executes MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU and produces the 64-bit HI/LO result plus a one-cycle write strobe for the downstream hilo register.
- Pipeline stalls on busy. The current HI/LO value is fed back so accumulate ops can read it.

Parameters:
MUL_CYCLES, 1, number of internal multiply states before DONE (1..4); MUL latency = MUL_CYCLES+1
DIV_ZERO_Q, 32'hFFFF_FFFF, quotient produced on divide-by-zero

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (rst==0 resets immediately)
start  in  1  request; sampled only when busy==0
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
reg1  in  32  rs operand (multiplicand / dividend)
reg2  in  32  rt operand (multiplier / divisor)
hilo_rddata  in  64  current {HI,LO} from hilo register
flush  in  1  synchronous cancel (exception / branch squash)
busy  out  1  unit occupied; pipeline must stall HI/LO consumers and new mult/div ops
hilo_we  out  1  one-cycle write strobe to hilo
hilo_wrdata  out  64  {HI,LO} result; valid only while hilo_we==1

Behaviour:
- States: IDLE, MUL, DIV, FIX, DONE. Reset: IDLE, busy=0, hilo_we=0, hilo_wrdata=0, all internal registers 0.
- busy = (state != IDLE). hilo_we = (state==DONE) && !flush.
- IDLE: on start==1 && flush==0 at edge T, latch op, reg1, reg2 and hilo_rddata (accumulator snapshot).
  - Multiply ops go to MUL; divide ops go to DIV with count=0.
- MUL: form the 64-bit product (signed for MULT/MADD/MSUB, unsigned otherwise), taking MUL_CYCLES cycles, then go to DONE.
  - Product arithmetic is modulo 2^64.
  - MADD*: result = snapshot + product. MSUB*: result = snapshot - product.
  - Default latency: hilo_we high in cycle T+2.
- DIV: restoring radix-2 on operand magnitudes (two's-complement absolute value for DIV), one quotient bit per cycle.
  - count 0..31; after count==31 go to FIX.
- FIX (1 cycle): apply signs.
  - Quotient is negated iff the operand signs differ (DIV only); truncation is toward zero.
  - Remainder takes the sign of the dividend.
  - Then go to DONE. Divide: hilo_we high in cycle T+34.
- Divide-by-zero (reg2==0, any divide op): still takes the full 34 cycles. Result LO=DIV_ZERO_Q, HI=reg1 unmodified.
- Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0. No exception.
- Result format: multiply {HI,LO} = result[63:32], result[31:0]. Divide HI=remainder, LO=quotient.
- DONE: lasts exactly 1 cycle with hilo_we=1, then IDLE. A new start is accepted only in the following IDLE cycle, so back-to-back ops have a 1-cycle gap.
- start while busy: ignored, with no queuing.
- flush: in any non-IDLE state, next state = IDLE, and hilo_we is suppressed in the same cycle (including in DONE).
  - flush with start in IDLE: start is dropped.
- Reset asserted mid-operation: immediate return to reset values. No write is issued after rst deasserts.
- Operands are held internally, so reg1/reg2/hilo_rddata may change after T without effect.

Test Plan:
- MULT reg1=0xFFFF_FFFD (-3), reg2=5 -> hilo_we at T+2 only, wrdata=0xFFFF_FFFF_FFFF_FFF1. busy high T+1..T+2.
- MADDU reg1=reg2=0xFFFF_FFFF, hilo_rddata=0x0000_0000_0000_0001 -> wrdata=0xFFFF_FFFE_0000_0002. MSUB same operands, hilo 0 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV -7/2 (0xFFFF_FFF9, 2) -> hilo_we at T+34, wrdata=0xFFFF_FFFF_FFFF_FFFD. DIV 0x8000_0000/0xFFFF_FFFF -> 0x0000_0000_8000_0000.
- DIVU 0x8000_0000/0 -> T+34, wrdata=0x8000_0000_FFFF_FFFF. Second start pulsed at T+5 is ignored, with no extra hilo_we.
- DIVU started, flush=1 at T+10 -> busy=0 from T+11, hilo_we never asserted. A new MULTU 2*3 at T+11 gives 0x6 at T+13. flush during DONE suppresses that write.
- rst pulled low at T+20 of a DIV -> busy and hilo_we drop to 0 immediately. After release, idle with no spurious write for 40 cycles.
